reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter.sv | 93 +++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for writes into one shared register.
// A winner may lock ownership for as long as it keeps requesting.
module reg_write_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N-1:0]           req,
  input  logic [N-1:0]           lock,
  input  logic [N*WIDTH-1:0]     wdata,
  output logic [N-1:0]           gnt,
  output logic [WIDTH-1:0]       q,
  output logic                   q_valid,
  output logic                   upd,
  output logic [$clog2(N)-1:0]   upd_id
);

  localparam int IW = $clog2(N);

  typedef enum logic {ARB, LOCKED} mode_t;

  mode_t          mode, mode_n;
  logic [IW-1:0]  ptr, ptr_n;
  logic [IW-1:0]  owner, owner_n;
  logic [IW-1:0]  win;
  logic           has_win;
  logic [WIDTH-1:0] wsel;

  // Winner: the locked owner while it still requests, otherwise the first
  // requester at or after ptr. A dropped owner falls straight into the scan.
  always_comb begin
    int unsigned idx;
    has_win = 1'b0;
    win     = '0;
    idx     = 0;
    if (mode == LOCKED && req[owner]) begin
      has_win = 1'b1;
      win     = owner;
    end else begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = int'(ptr) + i;
        if (idx >= N) idx = idx - N;
        if (!has_win && req[idx]) begin
          has_win = 1'b1;
          win     = IW'(idx);
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (reset && has_win) gnt[win] = 1'b1;
  end

  always_comb begin
    wsel    = wdata[int'(win)*WIDTH +: WIDTH];
    ptr_n   = ptr;
    mode_n  = ARB;
    owner_n = owner;
    if (has_win) begin
      ptr_n = (win == IW'(N-1)) ? '0 : win + IW'(1);
      if (lock[win]) begin
        mode_n  = LOCKED;
        owner_n = win;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr     <= '0;
      mode    <= ARB;
      owner   <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      upd     <= 1'b0;
      upd_id  <= '0;
    end else begin
      ptr   <= ptr_n;
      mode  <= mode_n;
      owner <= owner_n;
      upd   <= has_win;
      if (has_win) begin
        q       <= wsel;
        q_valid <= 1'b1;
        upd_id  <= win;
      end
    end
  end

endmodule
